// File: rtl/arbitro_mux2x1.sv
// arbitro_mux2x1: round-robin arbiter for two requesters that share one
// 2:1 multiplexer. The grant drives the mux select. The selected word is
// registered together with a valid flag. The burst limit stops one
// requester from keeping the channel while the other one waits.
module arbitro_mux2x1 #(
  parameter int WIDTH     = 8,
  parameter int MAX_BURST = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req1,
  input  logic             req2,
  input  logic [WIDTH-1:0] din1,
  input  logic [WIDTH-1:0] din2,
  output logic             gnt1,
  output logic             gnt2,
  output logic             sel,
  output logic [WIDTH-1:0] dout,
  output logic             dout_valid
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    GNT1 = 2'd1,
    GNT2 = 2'd2
  } state_t;

  // The counter needs at least one bit, even when MAX_BURST = 1.
  localparam int CNT_W = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_BURST - 1);

  state_t           r_state;
  state_t           w_next_state;
  logic [CNT_W-1:0] r_cnt;
  logic             r_last2;       // 1: requester 2 was granted last
  logic             r_sel;
  logic [WIDTH-1:0] r_dout;
  logic             r_dout_valid;
  logic             w_xfer;
  logic             w_burst_open;  // current holder may keep the grant under contention

  // State register
  // NOTE: state is written with <= so every flop samples pre-edge values.
  //       Blocking assignments here would create races between always_ff blocks.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next_state;
  end

  assign w_burst_open = (r_cnt < CNT_MAX);

  // Next-state logic: round-robin on ties, burst limit under contention
  // NOTE: the default assignment comes first, so no path leaves
  //       w_next_state unassigned. That prevents an inferred latch.
  always_comb begin
    w_next_state = r_state;
    unique case (r_state)
      IDLE: begin
        if (req1 && req2)  w_next_state = r_last2 ? GNT1 : GNT2;
        else if (req1)     w_next_state = GNT1;
        else if (req2)     w_next_state = GNT2;
        else               w_next_state = IDLE;
      end
      GNT1: begin
        if (req1 && (!req2 || w_burst_open)) w_next_state = GNT1;
        else if (req2)                       w_next_state = GNT2;
        else                                 w_next_state = IDLE;
      end
      GNT2: begin
        if (req2 && (!req1 || w_burst_open)) w_next_state = GNT2;
        else if (req1)                       w_next_state = GNT1;
        else                                 w_next_state = IDLE;
      end
      default: w_next_state = IDLE;
    endcase
  end

  // Burst counter: clear on any state change, else count up and saturate while granted
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (w_next_state != r_state) begin
      r_cnt <= '0;
    end else if ((r_state != IDLE) && (r_cnt != CNT_MAX)) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  // Last-winner and select registers: updated on grant entry, held in IDLE
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_last2 <= 1'b1;
      r_sel   <= 1'b0;
    end else begin
      case (w_next_state)
        GNT1: begin
          r_last2 <= 1'b0;
          r_sel   <= 1'b0;
        end
        GNT2: begin
          r_last2 <= 1'b1;
          r_sel   <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Output decode from registered state only; no input reaches an output directly
  always_comb begin
    gnt1 = (r_state == GNT1);
    gnt2 = (r_state == GNT2);
    sel  = r_sel;
  end

  // A requester that drops while granted transfers nothing that cycle.
  assign w_xfer = ((r_state == GNT1) && req1) || ((r_state == GNT2) && req2);

  // Output datapath: capture the selected word on a transfer, otherwise hold it
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_dout       <= '0;
      r_dout_valid <= 1'b0;
    end else begin
      r_dout_valid <= w_xfer;
      if (w_xfer) r_dout <= r_sel ? din2 : din1;
    end
  end

  assign dout       = r_dout;
  assign dout_valid = r_dout_valid;

endmodule

// File: tb/tb_arbitro_mux2x1.sv
// tb_arbitro_mux2x1: directed bench with hand-computed expectations.
// Instance a uses WIDTH=8 and MAX_BURST=4. Instance b uses WIDTH=4 and
// MAX_BURST=1. Inputs change 1 ns after a rising edge. Outputs are
// sampled at that same point, before new inputs are driven.
module tb_arbitro_mux2x1;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       req1_a, req2_a;
  logic [7:0] din1_a, din2_a;
  logic       gnt1_a, gnt2_a, sel_a, valid_a;
  logic [7:0] dout_a;
  logic       req1_b, req2_b;
  logic [3:0] din1_b, din2_b;
  logic       gnt1_b, gnt2_b, sel_b, valid_b;
  logic [3:0] dout_b;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  arbitro_mux2x1 #(.WIDTH(8), .MAX_BURST(4)) u_dut_a (
    .clk(clk), .rst_n(rst_n), .req1(req1_a), .req2(req2_a),
    .din1(din1_a), .din2(din2_a), .gnt1(gnt1_a), .gnt2(gnt2_a),
    .sel(sel_a), .dout(dout_a), .dout_valid(valid_a)
  );

  arbitro_mux2x1 #(.WIDTH(4), .MAX_BURST(1)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .req1(req1_b), .req2(req2_b),
    .din1(din1_b), .din2(din2_b), .gnt1(gnt1_b), .gnt2(gnt2_b),
    .sel(sel_b), .dout(dout_b), .dout_valid(valid_b)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // Advance to 1 ns after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_a(input string tag, input logic g1, input logic g2, input logic s,
                         input logic v, input logic [7:0] d);
    check({tag, ".gnt1"}, gnt1_a, g1);
    check({tag, ".gnt2"}, gnt2_a, g2);
    check({tag, ".sel"},  sel_a,  s);
    check({tag, ".valid"}, valid_a, v);
    check({tag, ".dout"}, dout_a, d);
  endtask

  initial begin
    rst_n  = 1'b0;
    req1_a = 1'b0; req2_a = 1'b0; din1_a = 8'h00; din2_a = 8'h00;
    req1_b = 1'b0; req2_b = 1'b0; din1_b = 4'h0; din2_b = 4'h0;

    // Reset state
    #2;
    check_a("reset", 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
    check("reset.b_valid", valid_b, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    step();

    // Single requester: grant at edge 1, data at edge 2, sel stays 0
    req1_a = 1'b1; din1_a = 8'hA5;
    step();
    check_a("solo.e1", 1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
    step();
    check_a("solo.e2", 1'b1, 1'b0, 1'b0, 1'b1, 8'hA5);
    step();
    check_a("solo.e3", 1'b1, 1'b0, 1'b0, 1'b1, 8'hA5);

    // Asynchronous reset mid-burst: outputs clear without a clock edge
    #3;
    rst_n = 1'b0;
    #1;
    check_a("async_rst", 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
    req1_a = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    step();

    // First tie after reset: 4 x GNT1, 4 x GNT2, then GNT1 again
    req1_a = 1'b1; req2_a = 1'b1; din1_a = 8'h11; din2_a = 8'h22;
    for (int e = 1; e <= 10; e++) begin
      logic       g1, g2, v;
      logic [7:0] d;
      step();
      g1 = (e <= 4) || (e >= 9);
      g2 = (e >= 5) && (e <= 8);
      v  = (e >= 2);
      d  = (e < 2) ? 8'h00 : ((e <= 5) || (e >= 10)) ? 8'h11 : 8'h22;
      check_a($sformatf("tie.e%0d", e), g1, g2, g2, v, d);
    end
    // Both drop while GNT1: IDLE next, no transfer, dout and sel hold
    req1_a = 1'b0; req2_a = 1'b0;
    step();
    check_a("tie.idle", 1'b0, 1'b0, 1'b0, 1'b0, 8'h11);

    // Tie with last = 1 goes to requester 2. Then req2 drops: handover with no bubble
    req1_a = 1'b1; req2_a = 1'b1; din1_a = 8'h3C; din2_a = 8'h5A;
    step();
    check_a("hand.e1", 1'b0, 1'b1, 1'b1, 1'b0, 8'h11);
    step();
    check_a("hand.e2", 1'b0, 1'b1, 1'b1, 1'b1, 8'h5A);
    req2_a = 1'b0;
    step();
    check_a("hand.e3", 1'b1, 1'b0, 1'b0, 1'b0, 8'h5A);
    step();
    check_a("hand.e4", 1'b1, 1'b0, 1'b0, 1'b1, 8'h3C);

    // Long solo hold on requester 1 saturates the counter
    for (int e = 5; e <= 12; e++) begin
      step();
      check_a($sformatf("hold.e%0d", e), 1'b1, 1'b0, 1'b0, 1'b1, 8'h3C);
    end
    // req2 rises right after an edge. The grant moves on the following edge
    req2_a = 1'b1; din2_a = 8'h77;
    step();
    check_a("preempt.k", 1'b0, 1'b1, 1'b1, 1'b1, 8'h3C);
    step();
    check_a("preempt.k1", 1'b0, 1'b1, 1'b1, 1'b1, 8'h77);
    req1_a = 1'b0; req2_a = 1'b0;
    step();
    check_a("preempt.end", 1'b0, 1'b0, 1'b1, 1'b0, 8'h77);

    // MAX_BURST = 1: the grant alternates every cycle. dout = 3, C, 3, C
    req1_b = 1'b1; req2_b = 1'b1; din1_b = 4'h3; din2_b = 4'hC;
    step();
    check("mb1.e1.gnt1", gnt1_b, 1'b1);
    check("mb1.e1.valid", valid_b, 1'b0);
    for (int e = 2; e <= 5; e++) begin
      step();
      check($sformatf("mb1.e%0d.dout", e),  dout_b,  (e % 2 == 0) ? 4'h3 : 4'hC);
      check($sformatf("mb1.e%0d.valid", e), valid_b, 1'b1);
      check($sformatf("mb1.e%0d.sel", e),   sel_b,   (e % 2 == 0) ? 1'b1 : 1'b0);
    end
    req1_b = 1'b0; req2_b = 1'b0;
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
